// File: rtl/ysyx_22040759_axi_bridge.sv
// Single-outstanding AXI4 master that turns the core's read and write
// request streams into single-beat AXI4 transactions.
module ysyx_22040759_axi_bridge #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4,
   parameter int AXI_ID = 0
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                rd_addr_valid_i,
   input  logic [ADDR_W-1:0]   rd_addr_i,
   input  logic [1:0]          rd_size_i,
   output logic                rd_data_valid_o,
   output logic [DATA_W-1:0]   rd_data_o,

   input  logic                wr_valid_i,
   input  logic [ADDR_W-1:0]   wr_addr_i,
   input  logic [DATA_W-1:0]   wr_data_i,
   input  logic [DATA_W/8-1:0] wr_strb_i,
   input  logic [1:0]          wr_size_i,
   output logic                wr_done_o,

   output logic                bus_err_o,

   output logic                arvalid,
   input  logic                arready,
   output logic [ADDR_W-1:0]   araddr,
   output logic [ID_W-1:0]     arid,
   output logic [7:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,

   input  logic                rvalid,
   output logic                rready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic [ID_W-1:0]     rid,

   output logic                awvalid,
   input  logic                awready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [ID_W-1:0]     awid,
   output logic [7:0]          awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,

   output logic                wvalid,
   input  logic                wready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,

   input  logic                bvalid,
   output logic                bready,
   input  logic [1:0]          bresp,
   input  logic [ID_W-1:0]     bid
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_ADDR = 3'd1;
   localparam logic [2:0] RD_DATA = 3'd2;
   localparam logic [2:0] RD_DONE = 3'd3;
   localparam logic [2:0] WR_REQ  = 3'd4;
   localparam logic [2:0] WR_RESP = 3'd5;
   localparam logic [2:0] WR_DONE = 3'd6;

   logic [2:0]          state, state_n;
   logic                aw_done, w_done;
   logic                aw_ok, w_ok;
   logic                err_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic [DATA_W/8-1:0] strb_q;
   logic [1:0]          size_q;

   logic unused_inputs;
   assign unused_inputs = ^{rlast, rid, bid, rresp[0], bresp[0]};

   assign arvalid = (state == RD_ADDR);
   assign rready  = (state == RD_DATA);
   assign awvalid = (state == WR_REQ) && !aw_done;
   assign wvalid  = (state == WR_REQ) && !w_done;
   assign bready  = (state == WR_RESP);

   assign rd_data_valid_o = (state == RD_DONE);
   assign wr_done_o       = (state == WR_DONE);
   assign bus_err_o       = (rd_data_valid_o || wr_done_o) && err_q;

   assign araddr  = addr_q;
   assign awaddr  = addr_q;
   assign arsize  = {1'b0, size_q};
   assign awsize  = {1'b0, size_q};
   assign arlen   = 8'd0;
   assign awlen   = 8'd0;
   assign arburst = 2'b01;
   assign awburst = 2'b01;
   assign arid    = ID_W'(AXI_ID);
   assign awid    = ID_W'(AXI_ID);
   assign wdata   = data_q;
   assign wstrb   = strb_q;
   assign wlast   = wvalid;

   // a handshake counts as done if it happened earlier or happens now
   assign aw_ok = aw_done || (awvalid && awready);
   assign w_ok  = w_done || (wvalid && wready);

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (wr_valid_i)
               state_n = WR_REQ;
            else if (rd_addr_valid_i)
               state_n = RD_ADDR;
         end
         RD_ADDR: if (arready) state_n = RD_DATA;
         RD_DATA: if (rvalid) state_n = RD_DONE;
         RD_DONE: state_n = IDLE;
         WR_REQ:  if (aw_ok && w_ok) state_n = WR_RESP;
         WR_RESP: if (bvalid) state_n = WR_DONE;
         WR_DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         err_q     <= 1'b0;
         rd_data_o <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         size_q    <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE) begin
            if (wr_valid_i) begin
               addr_q <= wr_addr_i;
               data_q <= wr_data_i;
               strb_q <= wr_strb_i;
               size_q <= wr_size_i;
            end else if (rd_addr_valid_i) begin
               addr_q <= rd_addr_i;
               size_q <= rd_size_i;
            end
         end
         if (state == WR_REQ && state_n == WR_REQ) begin
            aw_done <= aw_ok;
            w_done  <= w_ok;
         end else begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (state == RD_DATA && rvalid) begin
            rd_data_o <= rdata;
            err_q     <= rresp[1];
         end
         if (state == WR_RESP && bvalid)
            err_q <= bresp[1];
      end
   end

endmodule

// File: tb/tb_ysyx_22040759_axi_bridge.sv
// Directed bench for the single-outstanding AXI bridge.
// Inputs change and outputs are sampled on the falling edge.
module tb_ysyx_22040759_axi_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_addr_valid_i;
   logic [63:0] rd_addr_i;
   logic [1:0]  rd_size_i;
   logic        rd_data_valid_o;
   logic [63:0] rd_data_o;
   logic        wr_valid_i;
   logic [63:0] wr_addr_i;
   logic [63:0] wr_data_i;
   logic [7:0]  wr_strb_i;
   logic [1:0]  wr_size_i;
   logic        wr_done_o;
   logic        bus_err_o;
   logic        arvalid, arready;
   logic [63:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid, rready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic [3:0]  rid;
   logic        awvalid, awready;
   logic [63:0] awaddr;
   logic [3:0]  awid;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        wvalid, wready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast;
   logic        bvalid, bready;
   logic [1:0]  bresp;
   logic [3:0]  bid;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ysyx_22040759_axi_bridge dut (
      .clk(clk), .rst(rst),
      .rd_addr_valid_i(rd_addr_valid_i), .rd_addr_i(rd_addr_i),
      .rd_size_i(rd_size_i), .rd_data_valid_o(rd_data_valid_o),
      .rd_data_o(rd_data_o),
      .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i),
      .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i),
      .wr_size_i(wr_size_i), .wr_done_o(wr_done_o),
      .bus_err_o(bus_err_o),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata),
      .rresp(rresp), .rlast(rlast), .rid(rid),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata),
      .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, " arvalid"}, 64'(arvalid), 64'd0);
      chk({tag, " rready"}, 64'(rready), 64'd0);
      chk({tag, " awvalid"}, 64'(awvalid), 64'd0);
      chk({tag, " wvalid"}, 64'(wvalid), 64'd0);
      chk({tag, " bready"}, 64'(bready), 64'd0);
      chk({tag, " rd_dv"}, 64'(rd_data_valid_o), 64'd0);
      chk({tag, " wr_done"}, 64'(wr_done_o), 64'd0);
      chk({tag, " bus_err"}, 64'(bus_err_o), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      rd_addr_valid_i = 0; rd_addr_i = '0; rd_size_i = '0;
      wr_valid_i = 0; wr_addr_i = '0; wr_data_i = '0;
      wr_strb_i = '0; wr_size_i = '0;
      arready = 0; rvalid = 0; rdata = '0; rresp = '0;
      rlast = 0; rid = '0;
      awready = 0; wready = 0; bvalid = 0; bresp = '0; bid = '0;

      // reset state
      repeat (2) @(negedge clk);
      chk_quiet("reset");
      chk("reset rd_data", rd_data_o, 64'd0);
      rst = 1'b0;

      // single read, minimum latency
      rd_addr_valid_i = 1; rd_addr_i = 64'h8000_0000;
      rd_size_i = 2'd3; arready = 1;
      @(negedge clk);
      chk("rd arvalid", 64'(arvalid), 64'd1);
      chk("rd araddr", araddr, 64'h8000_0000);
      chk("rd arsize", 64'(arsize), 64'd3);
      chk("rd arlen", 64'(arlen), 64'd0);
      chk("rd arburst", 64'(arburst), 64'd1);
      chk("rd arid", 64'(arid), 64'd0);
      @(negedge clk);
      chk("rd rready", 64'(rready), 64'd1);
      chk("rd arvalid off", 64'(arvalid), 64'd0);
      chk("rd dv early", 64'(rd_data_valid_o), 64'd0);
      rvalid = 1; rdata = 64'h1122334455667788; rresp = 2'b00;
      arready = 0;
      @(negedge clk);
      chk("rd dv", 64'(rd_data_valid_o), 64'd1);
      chk("rd data", rd_data_o, 64'h1122334455667788);
      chk("rd err", 64'(bus_err_o), 64'd0);
      chk("rd rready off", 64'(rready), 64'd0);
      rvalid = 0; rd_addr_valid_i = 0;
      @(negedge clk);
      chk("rd dv pulse", 64'(rd_data_valid_o), 64'd0);
      chk("rd idle arvalid", 64'(arvalid), 64'd0);

      // write, wready held low for 3 cycles
      wr_valid_i = 1; wr_addr_i = 64'h1000;
      wr_data_i = 64'hDEADBEEF_CAFEF00D; wr_strb_i = 8'hF0;
      wr_size_i = 2'd2; awready = 1; wready = 0;
      @(negedge clk);
      chk("wr awvalid c1", 64'(awvalid), 64'd1);
      chk("wr wvalid c1", 64'(wvalid), 64'd1);
      chk("wr wlast c1", 64'(wlast), 64'd1);
      chk("wr awaddr", awaddr, 64'h1000);
      chk("wr wdata", wdata, 64'hDEADBEEF_CAFEF00D);
      chk("wr wstrb", 64'(wstrb), 64'hF0);
      chk("wr awsize", 64'(awsize), 64'd2);
      chk("wr awlen", 64'(awlen), 64'd0);
      chk("wr awburst", 64'(awburst), 64'd1);
      wr_data_i = 64'h0;
      @(negedge clk);
      chk("wr awvalid c2", 64'(awvalid), 64'd0);
      chk("wr wvalid c2", 64'(wvalid), 64'd1);
      chk("wr wdata held", wdata, 64'hDEADBEEF_CAFEF00D);
      @(negedge clk);
      chk("wr awvalid c3", 64'(awvalid), 64'd0);
      chk("wr wvalid c3", 64'(wvalid), 64'd1);
      chk("wr bready c3", 64'(bready), 64'd0);
      @(negedge clk);
      chk("wr wvalid c4", 64'(wvalid), 64'd1);
      wready = 1;
      @(negedge clk);
      chk("wr wvalid c5", 64'(wvalid), 64'd0);
      chk("wr wlast c5", 64'(wlast), 64'd0);
      chk("wr bready", 64'(bready), 64'd1);
      chk("wr done early", 64'(wr_done_o), 64'd0);
      bvalid = 1; bresp = 2'b00;
      @(negedge clk);
      chk("wr done", 64'(wr_done_o), 64'd1);
      chk("wr err", 64'(bus_err_o), 64'd0);
      chk("wr bready off", 64'(bready), 64'd0);
      bvalid = 0; wr_valid_i = 0;
      @(negedge clk);
      chk("wr done pulse", 64'(wr_done_o), 64'd0);

      // simultaneous requests: write first, then read with SLVERR
      wr_valid_i = 1; wr_addr_i = 64'h2000; wr_data_i = 64'h55;
      wr_strb_i = 8'h01; wr_size_i = 2'd0;
      rd_addr_valid_i = 1; rd_addr_i = 64'h3000; rd_size_i = 2'd1;
      awready = 1; wready = 1; arready = 1;
      @(negedge clk);
      chk("sim awvalid", 64'(awvalid), 64'd1);
      chk("sim wvalid", 64'(wvalid), 64'd1);
      chk("sim arvalid c1", 64'(arvalid), 64'd0);
      chk("sim awaddr", awaddr, 64'h2000);
      bvalid = 1;
      @(negedge clk);
      chk("sim bready", 64'(bready), 64'd1);
      chk("sim arvalid c2", 64'(arvalid), 64'd0);
      @(negedge clk);
      chk("sim wr done", 64'(wr_done_o), 64'd1);
      chk("sim arvalid c3", 64'(arvalid), 64'd0);
      bvalid = 0; wr_valid_i = 0;
      @(negedge clk);
      chk("sim idle arvalid", 64'(arvalid), 64'd0);
      chk("sim idle done", 64'(wr_done_o), 64'd0);
      @(negedge clk);
      chk("sim arvalid", 64'(arvalid), 64'd1);
      chk("sim araddr", araddr, 64'h3000);
      chk("sim arsize", 64'(arsize), 64'd1);
      @(negedge clk);
      chk("sim rready", 64'(rready), 64'd1);
      rvalid = 1; rdata = 64'hA5A5; rresp = 2'b10;
      @(negedge clk);
      chk("err rd dv", 64'(rd_data_valid_o), 64'd1);
      chk("err bus_err", 64'(bus_err_o), 64'd1);
      chk("err rd data", rd_data_o, 64'hA5A5);
      rvalid = 0; rresp = 2'b00; rd_addr_valid_i = 0; arready = 0;
      @(negedge clk);
      chk("err bus_err off", 64'(bus_err_o), 64'd0);

      // arready withheld 5 cycles while rd_addr_i moves
      rd_addr_valid_i = 1; rd_addr_i = 64'h4440; rd_size_i = 2'd2;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         chk("stall arvalid", 64'(arvalid), 64'd1);
         chk("stall araddr", araddr, 64'h4440);
         rd_addr_i = 64'h9990 + 64'(i);
      end
      @(negedge clk);
      chk("stall arvalid c6", 64'(arvalid), 64'd1);
      chk("stall araddr c6", araddr, 64'h4440);
      arready = 1;
      @(negedge clk);
      chk("stall rready", 64'(rready), 64'd1);
      chk("stall arvalid off", 64'(arvalid), 64'd0);
      rvalid = 1; rdata = 64'h0BAD_F00D; rresp = 2'b00; arready = 0;
      @(negedge clk);
      chk("ok rd dv", 64'(rd_data_valid_o), 64'd1);
      chk("ok bus_err", 64'(bus_err_o), 64'd0);
      chk("ok rd data", rd_data_o, 64'h0BAD_F00D);
      rvalid = 0; rd_addr_valid_i = 0;
      @(negedge clk);

      // reset while in RD_DATA
      rd_addr_valid_i = 1; rd_addr_i = 64'h5000; rd_size_i = 2'd3;
      arready = 1;
      @(negedge clk);
      chk("rst arvalid", 64'(arvalid), 64'd1);
      @(negedge clk);
      chk("rst rready", 64'(rready), 64'd1);
      rst = 1; arready = 0;
      @(negedge clk);
      chk_quiet("rst mid");
      chk("rst rd_data", rd_data_o, 64'd0);
      rst = 0; rd_addr_valid_i = 0;
      rvalid = 1; rdata = 64'hFFFF; rresp = 2'b10;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst late rvalid dv", 64'(rd_data_valid_o), 64'd0);
         chk("rst late rready", 64'(rready), 64'd0);
      end
      rvalid = 0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
